photon_pulse_delay_mc: RTL and testbench
========================================

// Module: photon_pulse_delay_mc
// PURPOSE
//  Multi-channel programmable pulse delay/shaper for the single-photon counting front end.
//  Each channel detects rising edges on a detector pulse and replays each edge after a per-channel delay.
//  Each replayed pulse has a programmable width.
//  Up to DEPTH edges per channel may be in flight, so bursts shorter than the delay are preserved.
//  Outputs feed the coincidence/counter logic downstream.
// PARAMETERS
//  NUM_CH   4   number of independent channels
//  DELAY_W  8   delay config width; delay range 0..2^DELAY_W-1 cycles
//  WIDTH_W  4   output width config width; pulse high for width_cfg+1 cycles
//  DEPTH    8   in-flight edges per channel (power of 2, >=2)
// PORTS
//  clk            in   1                clock; one clock, all logic on rising edge
//  rst            in   1                reset is synchronous and active-high
//  en             in   1                1 = accept edges; 0 = flush and idle
//  clr_ovf        in   1                one-cycle pulse, clears all overflow flags
//  pulse          in   NUM_CH           detector pulses, already synchronous to clk
//  delay_cfg      in   NUM_CH*DELAY_W   per-channel delay, ch0 in LSBs
//  width_cfg      in   NUM_CH*WIDTH_W   per-channel output width-1, ch0 in LSBs
//  delayed_pulse  out  NUM_CH           delayed, shaped pulses
//  busy           out  NUM_CH           channel queue non-empty
//  overflow       out  NUM_CH           sticky: an edge was dropped on a full queue
// BEHAVIOUR
//  Reset: delayed_pulse=0, busy=0, overflow=0, all queues empty, edge history=0, timestamp=0.
//  Timestamp: free-running counter, DELAY_W+1 bits, wraps silently. Due-time compare is exact equality.
//   The extra bit makes wrap unambiguous for every legal delay.
//  Edge detect: edge at sampling edge k when pulse[c]=1 at k and pulse[c]=0 at k-1.
//   A level held high produces one edge.
//  Capture:
//   - On the edge, delay_cfg[c] is sampled and due = ts + delay + fixed offset is pushed.
//   - A later change to delay_cfg does not affect queued edges.
//  Latency: delayed_pulse[c] rises at edge k+2+delay_cfg[c]. Fixed pipeline overhead is 2 cycles.
//   delay_cfg=0 gives latency 2.
//  Width: width_cfg is sampled when the output fires. Output stays high for width_cfg+1 cycles.
//  Retrigger: if a due time hits while the output is already high, the width counter reloads.
//   The output stays high continuously (merged pulse, no glitch low).
//  Queue: per-channel FIFO of due times. Push and pop in the same cycle are both honoured.
//   - Empty: no pop, output unaffected.
//   - Full: a push with no simultaneous pop drops the new edge and sets overflow[c].
//   - Full with simultaneous pop: the push succeeds.
//  Ordering: edges replay in capture order. Delay is not monotonic across config changes.
//   If a later entry's due time passes before the head is popped, it is replayed only after a full timestamp wrap.
//   Software changes delay_cfg only when busy[c]=0.
//  busy[c]: registered, 1 while the FIFO holds >=1 entry. Not asserted during the output width tail.
//  overflow: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf clears it next edge.
//  en=0: the next edge empties all queues, forces delayed_pulse=0, and clears width counters.
//   The timestamp keeps running and edge history keeps tracking. A pulse already high when en rises is not an edge.
//  Reset mid-operation: all state returns to reset values on the next edge. No pending pulse is emitted.
//  Channels are fully independent. Simultaneous edges on all channels are all captured.
// CONFIGURATION
//  Macro PHOTON_DELAY_DROP_CNT_EN:
//   defined: adds output drop_cnt (NUM_CH*16). Per-channel 16-bit saturating count of dropped edges.
//    Cleared by rst and clr_ovf; increments on clr_ovf+drop in the same cycle resolve to 1.
//   undefined: no port, no counters. overflow flags only.
// TESTING
//  1. ch0 delay=10, width=0, single edge at cycle 100 -> delayed_pulse[0] high only at cycle 112. busy[0] high 101..112.
//  2. ch1 delay=0, width=3, edge at 50 -> output high cycles 52..55. Edge at 53 -> merged, high through 58.
//  3. ch2 delay=200, DEPTH=8, 9 edges every 4 cycles -> 8 replayed at +202 spacing 4. 9th dropped.
//     overflow[2]=1; drop_cnt=1 if enabled. clr_ovf -> 0.
//  4. Timestamp wrap: delay=255, edges straddling ts wrap 511->0 -> each output exactly 257 cycles after its edge.
//  5. Queue 3 edges on ch3, drop en at mid-flight -> no further outputs, busy[3]=0 next cycle. Same with rst.
//  6. All channels edge at the same cycle, delays 1/2/3/4 -> outputs at +3/+4/+5/+6. pulse held high 20 cycles -> one output.

Source files
------------

// File: rtl/photon_pulse_delay_mc.sv
// Multi-channel pulse delay/shaper: per-channel edge capture, due-time FIFO, programmable-width replay.
// Optional macro PHOTON_DELAY_DROP_CNT_EN adds per-channel saturating drop counters on drop_cnt.
module photon_pulse_delay_mc #(
    parameter int NUM_CH  = 4,
    parameter int DELAY_W = 8,
    parameter int WIDTH_W = 4,
    parameter int DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr_ovf,
    input  logic [NUM_CH-1:0]           pulse,
    input  logic [NUM_CH*DELAY_W-1:0]   delay_cfg,
    input  logic [NUM_CH*WIDTH_W-1:0]   width_cfg,
    output logic [NUM_CH-1:0]           delayed_pulse,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           overflow
`ifdef PHOTON_DELAY_DROP_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]        drop_cnt
`endif
);

    localparam int TS_W = DELAY_W + 1;
    localparam int AW   = $clog2(DEPTH);
    // Capture at edge k, visible in the queue at k+1, fires at k+2+delay.
    localparam logic [TS_W-1:0] PIPE_OFS = TS_W'(2);

    logic [TS_W-1:0]   ts;
    logic [NUM_CH-1:0] pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts      <= '0;
            pulse_q <= '0;
        end else begin
            ts      <= ts + TS_W'(1);
            pulse_q <= pulse;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [TS_W-1:0]    mem [DEPTH];
        logic [AW:0]        wr_ptr;
        logic [AW:0]        rd_ptr;
        logic [AW:0]        fill;
        logic [TS_W-1:0]    due;
        logic [TS_W-1:0]    head;
        logic [WIDTH_W-1:0] wcnt;
        logic               out_q;
        logic               busy_q;
        logic               ovf_q;
        logic               rise;
        logic               empty;
        logic               full;
        logic               pop;
        logic               push;
        logic               drop;

        assign fill  = wr_ptr - rd_ptr;
        assign empty = (fill == '0);
        assign full  = (fill == (AW+1)'(DEPTH));
        assign head  = mem[rd_ptr[AW-1:0]];
        assign rise  = pulse[c] & ~pulse_q[c];
        assign due   = ts + TS_W'(delay_cfg[c*DELAY_W +: DELAY_W]) + PIPE_OFS;
        assign pop   = en & ~empty & (head == ts);
        // A full queue still accepts an edge when the head leaves in the same cycle.
        assign push  = en & rise & (~full | pop);
        assign drop  = en & rise & full & ~pop;

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= due;
            end
        end

        always_ff @(posedge clk) begin
            if (rst || !en) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                out_q  <= 1'b0;
                wcnt   <= '0;
                busy_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
                busy_q <= ~empty;
                // A due hit while already high reloads the width, merging the pulses.
                if (pop) begin
                    out_q <= 1'b1;
                    wcnt  <= width_cfg[c*WIDTH_W +: WIDTH_W];
                end else if (out_q) begin
                    if (wcnt == '0) begin
                        out_q <= 1'b0;
                    end else begin
                        wcnt <= wcnt - WIDTH_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end

        assign delayed_pulse[c] = out_q;
        assign busy[c]          = busy_q;
        assign overflow[c]      = ovf_q;

`ifdef PHOTON_DELAY_DROP_CNT_EN
        logic [15:0] dcnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                dcnt <= '0;
            end else if (clr_ovf) begin
                dcnt <= drop ? 16'd1 : 16'd0;
            end else if (drop && (dcnt != 16'hFFFF)) begin
                dcnt <= dcnt + 16'd1;
            end
        end

        assign drop_cnt[c*16 +: 16] = dcnt;
`endif
    end

endmodule

// File: tb/tb_photon_pulse_delay_mc.sv
// Directed bench for photon_pulse_delay_mc: latency, width/merge, overflow, wrap, flush, parallel channels.
module tb_photon_pulse_delay_mc;

    localparam int NUM_CH  = 4;
    localparam int DELAY_W = 8;
    localparam int WIDTH_W = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      clr_ovf;
    logic [NUM_CH-1:0]         pulse;
    logic [NUM_CH*DELAY_W-1:0] delay_cfg;
    logic [NUM_CH*WIDTH_W-1:0] width_cfg;
    logic [NUM_CH-1:0]         delayed_pulse;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         overflow;
`ifdef PHOTON_DELAY_DROP_CNT_EN
    logic [NUM_CH*16-1:0]      drop_cnt;
`endif

    photon_pulse_delay_mc #(
        .NUM_CH (NUM_CH),
        .DELAY_W(DELAY_W),
        .WIDTH_W(WIDTH_W),
        .DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr_ovf      (clr_ovf),
        .pulse        (pulse),
        .delay_cfg    (delay_cfg),
        .width_cfg    (width_cfg),
        .delayed_pulse(delayed_pulse),
        .busy         (busy),
        .overflow     (overflow)
`ifdef PHOTON_DELAY_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rst_rel;
    int rises [NUM_CH];
    int high_cnt [NUM_CH];
    int first_rise [NUM_CH];
    int last_rise [NUM_CH];
    int last_high [NUM_CH];
    int busy_first [NUM_CH];
    int busy_last [NUM_CH];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // After tick() the edge numbered cyc has just been taken and its results are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic train(input int t, input int start, input int period,
                                   input int count, input int len);
        int d;
        if (t < start) return 1'b0;
        d = t - start;
        return ((d / period) < count) && ((d % period) < len);
    endfunction

    task automatic observe(input logic [NUM_CH-1:0] mask, input int start, input int period,
                           input int count, input int len, input int ncyc);
        logic [NUM_CH-1:0] prev;
        for (int c = 0; c < NUM_CH; c++) begin
            rises[c] = 0; high_cnt[c] = 0; first_rise[c] = -1; last_rise[c] = -1;
            last_high[c] = -1; busy_first[c] = -1; busy_last[c] = -1;
        end
        prev = delayed_pulse;
        for (int n = 0; n < ncyc; n++) begin
            for (int c = 0; c < NUM_CH; c++)
                if (mask[c]) pulse[c] = train(cyc + 1, start, period, count, len);
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                if (delayed_pulse[c]) begin
                    high_cnt[c]++;
                    last_high[c] = cyc;
                    if (!prev[c]) begin
                        rises[c]++;
                        if (first_rise[c] < 0) first_rise[c] = cyc;
                        last_rise[c] = cyc;
                    end
                end
                if (busy[c]) begin
                    if (busy_first[c] < 0) busy_first[c] = cyc;
                    busy_last[c] = cyc;
                end
            end
            prev = delayed_pulse;
        end
        pulse = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        rst_rel = cyc + 1;
    endtask

    initial begin
        int k;
        en = 1'b1; clr_ovf = 1'b0; pulse = '0; delay_cfg = '0; width_cfg = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_dp", int'(delayed_pulse), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        rst_rel = cyc + 1;
        repeat (2) tick();

        // ch0: delay 10, width 0, single edge
        delay_cfg[0*DELAY_W +: DELAY_W] = 8'd10;
        k = cyc + 2;
        observe(4'b0001, k, 1000, 1, 1, 30);
        chk("t1_rise", first_rise[0], k + 12);
        chk("t1_nrise", rises[0], 1);
        chk("t1_high", high_cnt[0], 1);
        chk("t1_busy_first", busy_first[0], k + 1);
        chk("t1_busy_last", busy_last[0], k + 12);

        // ch1: delay 0, width 3, second edge retriggers into one merged pulse
        width_cfg[1*WIDTH_W +: WIDTH_W] = 4'd3;
        k = cyc + 2;
        observe(4'b0010, k, 3, 2, 1, 20);
        chk("t2_rise", first_rise[1], k + 2);
        chk("t2_nrise", rises[1], 1);
        chk("t2_high", high_cnt[1], 7);
        chk("t2_last_high", last_high[1], k + 8);

        // ch2: delay 200, 9 edges every 4 cycles into an 8-deep queue
        delay_cfg[2*DELAY_W +: DELAY_W] = 8'd200;
        k = cyc + 2;
        observe(4'b0100, k, 4, 9, 1, 250);
        chk("t3_nrise", rises[2], 8);
        chk("t3_first", first_rise[2], k + 202);
        chk("t3_last", last_rise[2], k + 202 + 28);
        chk("t3_ovf", int'(overflow[2]), 1);
        chk("t3_ovf_other", int'(overflow[1:0]), 0);
`ifdef PHOTON_DELAY_DROP_CNT_EN
        chk("t3_dcnt", int'(drop_cnt[2*16 +: 16]), 1);
`endif
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", int'(overflow[2]), 0);
`ifdef PHOTON_DELAY_DROP_CNT_EN
        chk("t3_dcnt_clr", int'(drop_cnt[2*16 +: 16]), 0);
`endif

        // ch0: delay 255, edges at timestamps 508, 510, 0, 2
        delay_cfg[0*DELAY_W +: DELAY_W] = 8'd255;
        k = rst_rel + 508;
        while (k <= cyc + 1) k += 512;
        observe(4'b0001, k, 2, 4, 1, k - cyc + 270);
        chk("t4_nrise", rises[0], 4);
        chk("t4_first", first_rise[0], k + 257);
        chk("t4_last", last_rise[0], k + 6 + 257);
        chk("t4_high", high_cnt[0], 4);

        // ch3: three queued edges flushed by en=0, then by rst
        delay_cfg[3*DELAY_W +: DELAY_W] = 8'd50;
        k = cyc + 2;
        observe(4'b1000, k, 3, 3, 1, 12);
        chk("t5_busy_on", busy_first[3], k + 1);
        en = 1'b0;
        tick();
        en = 1'b1;
        observe(4'b0000, 0, 1, 0, 1, 80);
        chk("t5_en_nrise", rises[3], 0);
        chk("t5_en_busy", busy_first[3], -1);
        k = cyc + 2;
        observe(4'b1000, k, 3, 3, 1, 12);
        chk("t5b_busy_on", busy_first[3], k + 1);
        do_reset();
        observe(4'b0000, 0, 1, 0, 1, 80);
        chk("t5_rst_nrise", rises[3], 0);
        chk("t5_rst_busy", busy_first[3], -1);

        // all channels together, delays 1..4; then a 20-cycle held level
        delay_cfg = {8'd4, 8'd3, 8'd2, 8'd1};
        width_cfg = '0;
        k = cyc + 2;
        observe(4'b1111, k, 1000, 1, 1, 20);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("t6_rise_ch%0d", c), first_rise[c], k + 3 + c);
        k = cyc + 2;
        observe(4'b1111, k, 1000, 1, 20, 40);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("t6_hold_ch%0d", c), rises[c], 1);
        chk("t6_hold_rise0", first_rise[0], k + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
